fetch_buffer: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_buffer_if.sv | 29 ++
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_buffer.sv | 89 ++++++++
 tb/tb_fetch_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the rv32i fetch stage: data width, reset PC,
// and the PC-tagged instruction entry held in the prefetch FIFO.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect from execute,
// and the instruction handshake towards decode.
interface fetch_buffer_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  // instr/instr_pc are stable while instr_valid is high; a transfer happens on
  // any rising edge with instr_valid && instr_ready; instr_ready is a don't-care
  // while instr_valid is low.
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of PC-tagged instructions with push, pop and flush.
// Flush wins over push; pointers carry one extra wrap bit to tell full from empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage is reset too so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// rv32i fetch stage: owns fetch_pc, issues fixed-latency imem reads and buffers
// returned instructions for decode. FETCH_BUFFER_PERF_EN adds fetch/stall counters.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_buffer_if.master bus
`ifdef FETCH_BUFFER_PERF_EN
  ,
  output logic [31:0]    fetch_count,
  output logic [31:0]    stall_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W:0] DEPTH_W = (PTR_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_pc;
  logic             inflight;
  logic [PTR_W-1:0] count;
  logic [PTR_W:0]   used;
  logic             issue;
  logic             push;
  logic             pop;
  logic             empty;
  fetch_entry_t     head;
  fetch_entry_t     push_data;

  // Credit counts the in-flight request so the FIFO can never overflow;
  // a pop only frees credit from the following cycle.
  assign used      = {1'b0, count} + {{PTR_W{1'b0}}, inflight};
  assign issue     = rst_n && !bus.redirect_valid && (used < DEPTH_W);
  assign push      = inflight && !bus.redirect_valid;
  assign pop       = !empty && bus.instr_ready;
  assign push_data = '{instr: bus.imem_rdata, pc: req_pc};

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = !empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(1);
        req_pc   <= fetch_pc;
      end
    end
  end

`ifdef FETCH_BUFFER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push) fetch_count <= fetch_count + 32'd1;
      if (!empty && !bus.instr_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: memory model returns 0x1000_0000 | addr,
// a scoreboard queue holds the PCs decode should receive, in order.
module tb_fetch_buffer;
  import fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];

  fetch_buffer_if bus ();

`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_BUFFER_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model (1-cycle latency) ----------------
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= 32'h1000_0000 | bus.imem_addr;
    else              bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      logic [31:0] exp_pc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc %h, required no transfer", bus.instr_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (bus.instr_pc !== exp_pc || bus.instr !== (32'h1000_0000 | exp_pc)) begin
          errors++;
          $display("FAIL sb_data: got pc %h instr %h, required pc %h instr %h",
                   bus.instr_pc, bus.instr, exp_pc, 32'h1000_0000 | exp_pc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic rdy);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = rdy;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected transfers missing, required 0", name, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;
    #1;
    checks += 4;
    if (bus.imem_req !== 1'b0)    begin errors++; $display("FAIL reset_req: got %b, required 0", bus.imem_req); end
    if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", bus.instr_valid); end
    if (bus.instr !== 32'h0)      begin errors++; $display("FAIL reset_instr: got %h, required 0", bus.instr); end
    if (bus.instr_pc !== 32'h0)   begin errors++; $display("FAIL reset_pc: got %h, required 0", bus.instr_pc); end
`ifdef FETCH_BUFFER_PERF_EN
    checks += 2;
    if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_fetch_count: got %0d, required 0", fetch_count); end
    if (stall_count !== 32'h0) begin errors++; $display("FAIL reset_stall_count: got %0d, required 0", stall_count); end
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int p = 0; p < 6; p++) exp_q.push_back(32'(p));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks += 2;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
          errors++; $display("FAIL stream_first_req: got req %b addr %h, required 1 0", bus.imem_req, bus.imem_addr);
        end
        if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_c0: got %b, required 0", bus.instr_valid); end
      end
      if (c == 1) begin
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_c1: got %b, required 0", bus.instr_valid); end
      end
      if (c == 2) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== 32'h1000_0000) begin
          errors++; $display("FAIL stream_first_instr: got v %b pc %h instr %h, required 1 0 10000000",
                             bus.instr_valid, bus.instr_pc, bus.instr);
        end
      end
      if (c > 2) begin
        checks++;
        if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_gap c%0d: got %b, required 1", c, bus.instr_valid); end
      end
      next_cycle();
    end
    bus.instr_ready = 1'b0;
    check_drained("stream_drained");
  endtask

  task automatic test_backpressure();
    int req_cnt;
    req_cnt = 0;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) req_cnt++;
      if (c == 9) begin
        checks++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
          errors++; $display("FAIL bp_full: got req %b v %b pc %h, required 0 1 0", bus.imem_req, bus.instr_valid, bus.instr_pc);
        end
      end
      next_cycle();
    end
    checks++;
    if (req_cnt != 4) begin errors++; $display("FAIL bp_req_count: got %0d, required 4", req_cnt); end
    for (int p = 0; p < 8; p++) exp_q.push_back(32'(p));
    bus.instr_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_gap r%0d: got %b, required 1", r, bus.instr_valid); end
      if (r == 0) begin
        checks++;
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_no_early_credit: got %b, required 0", bus.imem_req); end
      end
      if (r == 1) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
          errors++; $display("FAIL bp_resume: got req %b addr %h, required 1 4", bus.imem_req, bus.imem_addr);
        end
      end
      next_cycle();
    end
    bus.instr_ready = 1'b0;
    check_drained("bp_drained");
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h41);
    exp_q.push_back(32'h42);
    for (int c = 0; c < 9; c++) begin
      bus.redirect_valid = (c == 3);
      bus.redirect_pc    = (c == 3) ? 32'h40 : 32'h0;
      if (c == 4) bus.instr_ready = 1'b1;
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_no_req: got %b, required 0", bus.imem_req); end
      end
      if (c == 4) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40 || bus.instr_valid !== 1'b0) begin
          errors++; $display("FAIL redir_req: got req %b addr %h v %b, required 1 40 0", bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble: got %b, required 0", bus.instr_valid); end
      end
      if (c == 6) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40) begin
          errors++; $display("FAIL redir_target: got v %b pc %h, required 1 40", bus.instr_valid, bus.instr_pc);
        end
      end
      next_cycle();
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    check_drained("redir_drained");
  endtask

  task automatic test_redirect_handshake();
    do_reset(1'b1);
    for (int p = 0; p < 6; p++) exp_q.push_back(32'(p));
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h41);
    for (int c = 0; c < 12; c++) begin
      bus.redirect_valid = (c == 7);
      bus.redirect_pc    = (c == 7) ? 32'h40 : 32'h0;
      @(negedge clk);
      if (c == 7) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h5) begin
          errors++; $display("FAIL rhs_pc5: got v %b pc %h, required 1 5", bus.instr_valid, bus.instr_pc);
        end
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rhs_bubble c%0d: got %b, required 0", c, bus.instr_valid); end
      end
      next_cycle();
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    check_drained("rhs_drained");
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
      errors++; $display("FAIL mid_reset_async: got req %b v %b instr %h pc %h, required 0 0 0 0",
                         bus.imem_req, bus.instr_valid, bus.instr, bus.instr_pc);
    end
    check_drained("mid_reset_pre");
    for (int p = 0; p < 3; p++) exp_q.push_back(32'(p));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
          errors++; $display("FAIL mid_reset_restart: got req %b addr %h, required 1 0", bus.imem_req, bus.imem_addr);
        end
      end
      next_cycle();
    end
    bus.instr_ready = 1'b0;
    check_drained("mid_reset_drained");
  endtask

`ifdef FETCH_BUFFER_PERF_EN
  task automatic test_perf();
    do_reset(1'b0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h41);
    for (int c = 0; c < 13; c++) begin
      if (c == 5)  bus.instr_ready = 1'b1;
      if (c == 12) bus.instr_ready = 1'b0;
      bus.redirect_valid = (c == 7);
      bus.redirect_pc    = (c == 7) ? 32'h40 : 32'h0;
      @(negedge clk);
      if (c == 5 || c == 8) begin
        checks++;
        if (fetch_count !== 32'd4 || stall_count !== 32'd3) begin
          errors++; $display("FAIL perf_c%0d: got fetch %0d stall %0d, required 4 3", c, fetch_count, stall_count);
        end
      end
      if (c == 12) begin
        checks++;
        if (fetch_count !== 32'd7 || stall_count !== 32'd3) begin
          errors++; $display("FAIL perf_c12: got fetch %0d stall %0d, required 7 3", fetch_count, stall_count);
        end
      end
      next_cycle();
    end
    bus.redirect_valid = 1'b0;
    check_drained("perf_drained");
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_handshake();
    test_reset_mid();
`ifdef FETCH_BUFFER_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
